// File: rtl/rs_alu_pkg.sv
// Shared definitions for the integer ALU path: opcode encoding used by the decoder,
// the ALU and its reservation station, plus the reservation-station entry states.
package rs_alu_pkg;

   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ISSUED = 2'd2
   } rs_state_e;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder; found_o is low when no request bit is set.
module rs_prio_enc #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = IDX_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs_alu.sv
// Integer ALU reservation station: buffers dispatched ops until operands resolve,
// issues one ready entry per cycle and broadcasts ALU results tagged with their ROB index.
module rs_alu
   import rs_alu_pkg::*;
#(
   parameter int ROB_WIDTH = 4,
   parameter int RS_WIDTH  = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [ALU_OP_W-1:0]  in_op,
   input  logic [31:0]          in_vj,
   input  logic [31:0]          in_vk,
   input  logic                 in_qj_busy,
   input  logic                 in_qk_busy,
   input  logic [ROB_WIDTH-1:0] in_qj,
   input  logic [ROB_WIDTH-1:0] in_qk,
   input  logic [ROB_WIDTH-1:0] in_rob,
   output logic                 full,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_tag,
   input  logic [31:0]          cdb_value,
   output logic                 alu_cal,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   output logic [ALU_OP_W-1:0]  alu_op,
   output logic [RS_WIDTH-1:0]  alu_rs_index,
   input  logic                 alu_done,
   input  logic [RS_WIDTH-1:0]  alu_done_index,
   input  logic [31:0]          alu_result,
   output logic                 out_valid,
   output logic [ROB_WIDTH-1:0] out_rob,
   output logic [31:0]          out_value
);

   localparam int NENT = 1 << RS_WIDTH;

   typedef struct packed {
      logic                 busy;
      logic [31:0]          val;
   } opnd_t;

   typedef struct packed {
      logic [ALU_OP_W-1:0]  op;
      opnd_t                j;
      opnd_t                k;
      logic [ROB_WIDTH-1:0] qj;
      logic [ROB_WIDTH-1:0] qk;
      logic [ROB_WIDTH-1:0] rob;
   } entry_t;

   rs_state_e            state_q [NENT];
   rs_state_e            state_d [NENT];
   entry_t               ent_q   [NENT];
   entry_t               ent_d   [NENT];

   logic                 alu_cal_q, alu_cal_d;
   logic [31:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [ALU_OP_W-1:0]  alu_op_q, alu_op_d;
   logic [RS_WIDTH-1:0]  alu_idx_q, alu_idx_d;
   logic                 out_valid_q, out_valid_d;
   logic [ROB_WIDTH-1:0] out_rob_q, out_rob_d;
   logic [31:0]          out_value_q, out_value_d;

   logic [NENT-1:0]      free_now, free_vec, ready_vec;
   logic [RS_WIDTH-1:0]  free_idx, sel_idx;
   logic                 free_found, sel_found;
   logic                 done_ok;
   logic [ROB_WIDTH-1:0] done_tag;

   // A return only counts for an entry still waiting on the ALU; stale ones after a flush drop out here.
   assign done_ok  = alu_done && (state_q[alu_done_index] == ST_ISSUED);
   assign done_tag = ent_q[alu_done_index].rob;
   assign full     = ~|free_now;

   always_comb begin
      for (int i = 0; i < NENT; i++) begin
         free_now[i]  = (state_q[i] == ST_FREE);
         free_vec[i]  = free_now[i] | (done_ok && (alu_done_index == RS_WIDTH'(i)));
         ready_vec[i] = (state_q[i] == ST_WAIT) && !ent_q[i].j.busy && !ent_q[i].k.busy;
      end
   end

   rs_prio_enc #(.N(NENT), .IDX_W(RS_WIDTH)) u_free_enc (
      .req_i   (free_vec),
      .idx_o   (free_idx),
      .found_o (free_found)
   );

   rs_prio_enc #(.N(NENT), .IDX_W(RS_WIDTH)) u_sel_enc (
      .req_i   (ready_vec),
      .idx_o   (sel_idx),
      .found_o (sel_found)
   );

   function automatic opnd_t wake(input opnd_t o, input logic [ROB_WIDTH-1:0] tag);
      opnd_t r;
      r = o;
      if (o.busy) begin
         if (cdb_valid && (tag == cdb_tag)) begin
            r.busy = 1'b0;
            r.val  = cdb_value;
         end else if (done_ok && (tag == done_tag)) begin
            r.busy = 1'b0;
            r.val  = alu_result;
         end
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < NENT; i++) begin
         state_d[i] = state_q[i];
         ent_d[i]   = ent_q[i];
      end
      alu_cal_d   = 1'b0;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      alu_idx_d   = alu_idx_q;
      out_valid_d = out_valid_q;
      out_rob_d   = out_rob_q;
      out_value_d = out_value_q;

      if (rdy_in && clear) begin
         for (int i = 0; i < NENT; i++) state_d[i] = ST_FREE;
         out_valid_d = 1'b0;
      end else if (rdy_in) begin
         for (int i = 0; i < NENT; i++) begin
            if (state_q[i] == ST_WAIT) begin
               ent_d[i].j = wake(ent_q[i].j, ent_q[i].qj);
               ent_d[i].k = wake(ent_q[i].k, ent_q[i].qk);
            end
         end
         if (sel_found) begin
            state_d[sel_idx] = ST_ISSUED;
            alu_cal_d        = 1'b1;
            alu_a_d          = ent_q[sel_idx].j.val;
            alu_b_d          = ent_q[sel_idx].k.val;
            alu_op_d         = ent_q[sel_idx].op;
            alu_idx_d        = sel_idx;
         end
         out_valid_d = done_ok;
         if (done_ok) begin
            state_d[alu_done_index] = ST_FREE;
            out_rob_d               = done_tag;
            out_value_d             = alu_result;
         end
         // The target may be the slot freed by this cycle's return; full only sees it next cycle.
         if (in_valid && !full && free_found) begin
            state_d[free_idx]   = ST_WAIT;
            ent_d[free_idx].op  = in_op;
            ent_d[free_idx].qj  = in_qj;
            ent_d[free_idx].qk  = in_qk;
            ent_d[free_idx].rob = in_rob;
            ent_d[free_idx].j   = wake('{busy: in_qj_busy, val: in_vj}, in_qj);
            ent_d[free_idx].k   = wake('{busy: in_qk_busy, val: in_vk}, in_qk);
         end
      end else if (done_ok) begin
         // Stalled: only the in-flight return is taken, and its broadcast is held until release.
         state_d[alu_done_index] = ST_FREE;
         out_valid_d             = 1'b1;
         out_rob_d               = done_tag;
         out_value_d             = alu_result;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NENT; i++) state_q[i] <= ST_FREE;
         alu_cal_q   <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_rob_q   <= '0;
         out_value_q <= '0;
      end else begin
         for (int i = 0; i < NENT; i++) state_q[i] <= state_d[i];
         alu_cal_q   <= alu_cal_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         alu_idx_q   <= alu_idx_d;
         out_valid_q <= out_valid_d;
         out_rob_q   <= out_rob_d;
         out_value_q <= out_value_d;
      end
   end

   // Entry payload is qualified by state, so it carries no reset.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < NENT; i++) ent_q[i] <= ent_d[i];
   end

   assign alu_cal      = alu_cal_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign alu_rs_index = alu_idx_q;
   assign out_valid    = out_valid_q;
   assign out_rob      = out_rob_q;
   assign out_value    = out_value_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu with a one-cycle ALU stand-in that can be swapped for manual returns.
module tb_rs_alu;
   import rs_alu_pkg::*;

   localparam int ROB_W = 4;
   localparam int RS_W  = 2;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b0;
   logic              rdy_in = 1'b1;
   logic              clear  = 1'b0;
   logic              in_valid = 1'b0;
   logic [3:0]        in_op = 4'd0;
   logic [31:0]       in_vj = 32'd0, in_vk = 32'd0;
   logic              in_qj_busy = 1'b0, in_qk_busy = 1'b0;
   logic [ROB_W-1:0]  in_qj = '0, in_qk = '0, in_rob = '0;
   logic              full;
   logic              cdb_valid = 1'b0;
   logic [ROB_W-1:0]  cdb_tag = '0;
   logic [31:0]       cdb_value = 32'd0;
   logic              alu_cal;
   logic [31:0]       alu_a, alu_b;
   logic [3:0]        alu_op;
   logic [RS_W-1:0]   alu_rs_index;
   logic              alu_done;
   logic [RS_W-1:0]   alu_done_index;
   logic [31:0]       alu_result;
   logic              out_valid;
   logic [ROB_W-1:0]  out_rob;
   logic [31:0]       out_value;

   logic              alu_auto = 1'b1;
   logic              m_done = 1'b0, man_done = 1'b0;
   logic [RS_W-1:0]   m_idx = '0, man_idx = '0;
   logic [31:0]       m_res = 32'd0, man_res = 32'd0;

   int n_checks = 0;
   int n_fail   = 0;

   rs_alu #(.ROB_WIDTH(ROB_W), .RS_WIDTH(RS_W)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .clear          (clear),
      .in_valid       (in_valid),
      .in_op          (in_op),
      .in_vj          (in_vj),
      .in_vk          (in_vk),
      .in_qj_busy     (in_qj_busy),
      .in_qk_busy     (in_qk_busy),
      .in_qj          (in_qj),
      .in_qk          (in_qk),
      .in_rob         (in_rob),
      .full           (full),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_value      (cdb_value),
      .alu_cal        (alu_cal),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_op         (alu_op),
      .alu_rs_index   (alu_rs_index),
      .alu_done       (alu_done),
      .alu_done_index (alu_done_index),
      .alu_result     (alu_result),
      .out_valid      (out_valid),
      .out_rob        (out_rob),
      .out_value      (out_value)
   );

   always #5 clk_in = ~clk_in;

   // ALU stand-in: answers one cycle after each issue strobe.
   always @(posedge clk_in) begin
      m_done <= alu_cal;
      m_idx  <= alu_rs_index;
      case (alu_op)
         ALU_ADD: m_res <= alu_a + alu_b;
         ALU_SUB: m_res <= alu_a - alu_b;
         default: m_res <= 32'd0;
      endcase
   end

   assign alu_done       = alu_auto ? m_done : man_done;
   assign alu_done_index = alu_auto ? m_idx  : man_idx;
   assign alu_result     = alu_auto ? m_res  : man_res;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                       input logic [3:0] rob);
      in_valid = 1'b1; in_op = op; in_vj = vj; in_vk = vk;
      in_qj_busy = qjb; in_qj = qj; in_qk_busy = qkb; in_qk = qk; in_rob = rob;
   endtask

   task automatic test_reset();
      step();
      n_checks++;
      if ({alu_cal, alu_a, alu_b, alu_op, alu_rs_index, out_valid, out_rob, out_value, full} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got cal=%0b a=%h b=%h op=%h idx=%0d ov=%0b rob=%0d val=%h full=%0b want all 0",
                  alu_cal, alu_a, alu_b, alu_op, alu_rs_index, out_valid, out_rob, out_value, full);
      end
      rst_in = 1'b1;
      step();
   endtask

   task automatic test_ready();
      disp(ALU_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
      step(); in_valid = 1'b0;
      n_checks++;
      if ({alu_cal, full} !== 2'b00) begin
         n_fail++; $display("FAIL ready_edge0: cal=%0b full=%0b want 0 0", alu_cal, full);
      end
      step();
      n_checks++;
      if ({alu_cal, alu_a, alu_b, alu_op, alu_rs_index} !== {1'b1, 32'd5, 32'd7, ALU_ADD, 2'd0}) begin
         n_fail++; $display("FAIL ready_issue: cal=%0b a=%0d b=%0d op=%0d idx=%0d want 1 5 7 0 0",
                            alu_cal, alu_a, alu_b, alu_op, alu_rs_index);
      end
      step();
      n_checks++;
      if ({alu_cal, out_valid} !== 2'b00) begin
         n_fail++; $display("FAIL ready_edge2: cal=%0b ov=%0b want 0 0", alu_cal, out_valid);
      end
      step();
      n_checks++;
      if ({out_valid, out_rob, out_value} !== {1'b1, 4'd3, 32'd12}) begin
         n_fail++; $display("FAIL ready_result: ov=%0b rob=%0d val=%0d want 1 3 12", out_valid, out_rob, out_value);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL ready_drop: ov=%0b want 0", out_valid);
      end
   endtask

   task automatic test_cdb_wakeup();
      disp(ALU_SUB, 32'd0, 32'd1, 1'b1, 4'd9, 1'b0, 4'd0, 4'd4);
      step(); in_valid = 1'b0;
      step();
      n_checks++;
      if (alu_cal !== 1'b0) begin
         n_fail++; $display("FAIL cdb_wait: cal=%0b want 0", alu_cal);
      end
      cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'd100;
      step(); cdb_valid = 1'b0;
      n_checks++;
      if (alu_cal !== 1'b0) begin
         n_fail++; $display("FAIL cdb_no_bypass: cal=%0b want 0", alu_cal);
      end
      step();
      n_checks++;
      if ({alu_cal, alu_a, alu_b, alu_op, alu_rs_index} !== {1'b1, 32'd100, 32'd1, ALU_SUB, 2'd0}) begin
         n_fail++; $display("FAIL cdb_issue: cal=%0b a=%0d b=%0d op=%0d idx=%0d want 1 100 1 1 0",
                            alu_cal, alu_a, alu_b, alu_op, alu_rs_index);
      end
      step(); step();
      n_checks++;
      if ({out_valid, out_rob, out_value} !== {1'b1, 4'd4, 32'd99}) begin
         n_fail++; $display("FAIL cdb_result: ov=%0b rob=%0d val=%0d want 1 4 99", out_valid, out_rob, out_value);
      end
   endtask

   task automatic test_chain();
      disp(ALU_ADD, 32'd0, 32'd3, 1'b1, 4'd11, 1'b0, 4'd0, 4'd5);
      cdb_valid = 1'b1; cdb_tag = 4'd11; cdb_value = 32'd20;
      step(); cdb_valid = 1'b0;
      disp(ALU_ADD, 32'd0, 32'd1, 1'b1, 4'd5, 1'b0, 4'd0, 4'd6);
      step(); in_valid = 1'b0;
      n_checks++;
      if ({alu_cal, alu_a, alu_b, alu_rs_index} !== {1'b1, 32'd20, 32'd3, 2'd0}) begin
         n_fail++; $display("FAIL chain_capture: cal=%0b a=%0d b=%0d idx=%0d want 1 20 3 0",
                            alu_cal, alu_a, alu_b, alu_rs_index);
      end
      step();
      n_checks++;
      if (alu_cal !== 1'b0) begin
         n_fail++; $display("FAIL chain_dep_wait: cal=%0b want 0", alu_cal);
      end
      step();
      n_checks++;
      if ({out_valid, out_rob, out_value, alu_cal} !== {1'b1, 4'd5, 32'd23, 1'b0}) begin
         n_fail++; $display("FAIL chain_first: ov=%0b rob=%0d val=%0d cal=%0b want 1 5 23 0",
                            out_valid, out_rob, out_value, alu_cal);
      end
      step();
      n_checks++;
      if ({alu_cal, alu_a, alu_b, alu_rs_index} !== {1'b1, 32'd23, 32'd1, 2'd1}) begin
         n_fail++; $display("FAIL chain_dep_issue: cal=%0b a=%0d b=%0d idx=%0d want 1 23 1 1",
                            alu_cal, alu_a, alu_b, alu_rs_index);
      end
      step(); step();
      n_checks++;
      if ({out_valid, out_rob, out_value} !== {1'b1, 4'd6, 32'd24}) begin
         n_fail++; $display("FAIL chain_second: ov=%0b rob=%0d val=%0d want 1 6 24", out_valid, out_rob, out_value);
      end
      step();
   endtask

   task automatic test_fill_priority();
      alu_auto = 1'b0; man_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic exp_full;
         exp_full = (i == 3);
         disp(ALU_ADD, 32'd0, 32'(10 + i), 1'b1, 4'd14, 1'b0, 4'd0, 4'(i));
         step(); in_valid = 1'b0;
         n_checks++;
         if (full !== exp_full) begin
            n_fail++; $display("FAIL fill_full_%0d: full=%0b want %0b", i, full, exp_full);
         end
      end
      disp(ALU_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
      step(); in_valid = 1'b0;
      n_checks++;
      if ({full, alu_cal} !== 2'b10) begin
         n_fail++; $display("FAIL fill_ignore: full=%0b cal=%0b want 1 0", full, alu_cal);
      end
      cdb_valid = 1'b1; cdb_tag = 4'd14; cdb_value = 32'd1000;
      step(); cdb_valid = 1'b0;
      n_checks++;
      if (alu_cal !== 1'b0) begin
         n_fail++; $display("FAIL fill_wake: cal=%0b want 0", alu_cal);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({alu_cal, alu_a, alu_b, alu_rs_index} !== {1'b1, 32'd1000, 32'(10 + i), 2'(i)}) begin
            n_fail++; $display("FAIL fill_order_%0d: cal=%0b a=%0d b=%0d idx=%0d want 1 1000 %0d %0d",
                               i, alu_cal, alu_a, alu_b, alu_rs_index, 10 + i, i);
         end
      end
      step();
      n_checks++;
      if ({alu_cal, full} !== 2'b01) begin
         n_fail++; $display("FAIL fill_drained: cal=%0b full=%0b want 0 1", alu_cal, full);
      end
   endtask

   task automatic test_flush();
      man_done = 1'b1; man_idx = 2'd1; man_res = 32'd55;
      step(); man_done = 1'b0;
      n_checks++;
      if ({out_valid, out_rob, out_value, full} !== {1'b1, 4'd1, 32'd55, 1'b0}) begin
         n_fail++; $display("FAIL flush_pre_return: ov=%0b rob=%0d val=%0d full=%0b want 1 1 55 0",
                            out_valid, out_rob, out_value, full);
      end
      disp(ALU_ADD, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd8);
      step(); in_valid = 1'b0;
      n_checks++;
      if (full !== 1'b1) begin
         n_fail++; $display("FAIL flush_pre_full: full=%0b want 1", full);
      end
      clear = 1'b1;
      disp(ALU_ADD, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
      man_done = 1'b1; man_idx = 2'd0; man_res = 32'd77;
      step();
      clear = 1'b0; in_valid = 1'b0;
      man_idx = 2'd2; man_res = 32'd88;
      n_checks++;
      if ({full, alu_cal, out_valid} !== 3'b000) begin
         n_fail++; $display("FAIL flush_clear: full=%0b cal=%0b ov=%0b want 0 0 0", full, alu_cal, out_valid);
      end
      step(); man_done = 1'b0;
      n_checks++;
      if ({out_valid, full} !== 2'b00) begin
         n_fail++; $display("FAIL flush_stale_done: ov=%0b full=%0b want 0 0", out_valid, full);
      end
      step();
      n_checks++;
      if ({alu_cal, out_valid} !== 2'b00) begin
         n_fail++; $display("FAIL flush_no_issue: cal=%0b ov=%0b want 0 0", alu_cal, out_valid);
      end
      alu_auto = 1'b1;
      step();
   endtask

   task automatic test_stall();
      disp(ALU_ADD, 32'd2, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
      step(); in_valid = 1'b0;
      step();
      n_checks++;
      if ({alu_cal, alu_rs_index} !== {1'b1, 2'd0}) begin
         n_fail++; $display("FAIL stall_issue: cal=%0b idx=%0d want 1 0", alu_cal, alu_rs_index);
      end
      rdy_in = 1'b0;
      step();
      n_checks++;
      if ({alu_cal, out_valid} !== 2'b00) begin
         n_fail++; $display("FAIL stall_cal_off: cal=%0b ov=%0b want 0 0", alu_cal, out_valid);
      end
      step();
      n_checks++;
      if ({out_valid, out_rob, out_value} !== {1'b1, 4'd9, 32'd5}) begin
         n_fail++; $display("FAIL stall_latch: ov=%0b rob=%0d val=%0d want 1 9 5", out_valid, out_rob, out_value);
      end
      step();
      n_checks++;
      if ({out_valid, out_value} !== {1'b1, 32'd5}) begin
         n_fail++; $display("FAIL stall_hold: ov=%0b val=%0d want 1 5", out_valid, out_value);
      end
      rdy_in = 1'b1;
      step();
      n_checks++;
      if ({out_valid, full, alu_cal} !== 3'b000) begin
         n_fail++; $display("FAIL stall_release: ov=%0b full=%0b cal=%0b want 0 0 0", out_valid, full, alu_cal);
      end
   endtask

   task automatic test_reset_mid();
      disp(ALU_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
      step(); in_valid = 1'b0;
      step();
      n_checks++;
      if ({alu_cal, alu_a} !== {1'b1, 32'd1}) begin
         n_fail++; $display("FAIL rstmid_issue: cal=%0b a=%0d want 1 1", alu_cal, alu_a);
      end
      #2 rst_in = 1'b0;
      #1;
      n_checks++;
      if ({alu_cal, alu_a, alu_b, alu_op, alu_rs_index, out_valid, out_rob, out_value, full} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_async: got cal=%0b a=%h b=%h op=%h idx=%0d ov=%0b rob=%0d val=%h full=%0b want all 0",
                  alu_cal, alu_a, alu_b, alu_op, alu_rs_index, out_valid, out_rob, out_value, full);
      end
      step();
      rst_in = 1'b1;
      step();
      n_checks++;
      if ({alu_cal, out_valid, full} !== 3'b000) begin
         n_fail++; $display("FAIL rstmid_after: cal=%0b ov=%0b full=%0b want 0 0 0", alu_cal, out_valid, full);
      end
   endtask

   initial begin
      test_reset();
      test_ready();
      test_cdb_wakeup();
      test_chain();
      test_fill_priority();
      test_flush();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
